// File: rtl/two_to_one_mux.sv
// two_to_one_mux: bit-sliced 2:1 selector with an optional output register.
// The legs arrive packed as {leg1, leg0}. A consensus term keeps the output
// steady when both legs agree, even while s is unknown or glitching.
module two_to_one_mux #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic [2*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] w_leg0;
  logic [WIDTH-1:0] w_leg1;
  logic [WIDTH-1:0] w_sel;

  assign w_leg0 = d[WIDTH-1:0];
  assign w_leg1 = d[2*WIDTH-1:WIDTH];

  // Per-bit sum-of-products select. The leg0&leg1 consensus term holds the
  // output when both legs agree, independent of s.
  function automatic logic [WIDTH-1:0] mux_sel(
    input logic             sel,
    input logic [WIDTH-1:0] leg0,
    input logic [WIDTH-1:0] leg1
  );
    mux_sel = ({WIDTH{sel}} & leg1) | ({WIDTH{~sel}} & leg0) | (leg0 & leg1);
  endfunction

  // Combinational selection shared by both build variants
  always_comb begin
    w_sel = mux_sel(s, w_leg0, w_leg1);
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] r_out_p0;

      // Output register stage: reset takes priority over the data
      always_ff @(posedge clk) begin
        if (reset) begin
          r_out_p0 <= '0;
        end else begin
          r_out_p0 <= w_sel;
        end
      end

      assign out = r_out_p0;
    end else begin : g_comb
      // clk and reset have no function in the combinational build
      logic w_unused_ctl;
      assign w_unused_ctl = clk ^ reset;
      assign out          = w_sel;
    end
  endgenerate

endmodule

// File: tb/tb_two_to_one_mux.sv
// Directed bench for two_to_one_mux: combinational WIDTH=1 and WIDTH=5 builds
// plus a registered WIDTH=5 build, checked against hand-computed values.
module tb_two_to_one_mux;

  logic       clk;
  logic       reset;

  // WIDTH=1 combinational instance
  logic       s1;
  logic [1:0] d1;
  logic       out1;

  // WIDTH=5 combinational instance
  logic       s5;
  logic [9:0] d5;
  logic [4:0] out5;

  // WIDTH=5 registered instance
  logic       sr;
  logic [9:0] dr;
  logic [4:0] outr;

  int checks;
  int errors;

  two_to_one_mux #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
    .clk(clk), .reset(reset), .s(s1), .d(d1), .out(out1)
  );

  two_to_one_mux #(.WIDTH(5), .REGISTERED(1'b0)) u_c5 (
    .clk(clk), .reset(reset), .s(s5), .d(d5), .out(out5)
  );

  two_to_one_mux #(.WIDTH(5), .REGISTERED(1'b1)) u_r5 (
    .clk(clk), .reset(reset), .s(sr), .d(dr), .out(outr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] truth;
    logic [2:0] idx;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    s1 = 1'b0; d1 = 2'b00;
    s5 = 1'b0; d5 = '0;
    sr = 1'b0; dr = '0;

    // WIDTH=1 all-zero legs, both select states
    #1; check("w1_zero_s0", {4'b0, out1}, 5'b0);
    s1 = 1'b1; #1; check("w1_zero_s1", {4'b0, out1}, 5'b0);

    // WIDTH=1 exhaustive: index {s,d[1],d[0]}, expected bit per index 7..0
    truth = 8'b11001010;
    for (int i = 0; i < 8; i++) begin
      idx = i[2:0];
      s1 = idx[2];
      d1 = idx[1:0];
      #1;
      check($sformatf("w1_exh_%0d", i), {4'b0, out1}, {4'b0, truth[i]});
    end
    d1 = 2'b01; s1 = 1'b0; #1; check("w1_d01_s0", {4'b0, out1}, 5'b00001);
    s1 = 1'b1;             #1; check("w1_d01_s1", {4'b0, out1}, 5'b00000);
    d1 = 2'b10;            #1; check("w1_d10_s1", {4'b0, out1}, 5'b00001);

    // Consensus: agreeing legs ignore an unknown select
    d1 = 2'b11; s1 = 1'bx; #1; check("w1_cons_11", {4'b0, out1}, 5'b00001);
    d1 = 2'b00;            #1; check("w1_cons_00", {4'b0, out1}, 5'b00000);
    s1 = 1'b0;

    // WIDTH=5 alternating legs, toggling s every 400 ns
    d5 = {5'b01010, 5'b10101};
    s5 = 1'b0; #1; check("w5_s0_a", out5, 5'b10101);
    #399; s5 = 1'b1; #1; check("w5_s1_a", out5, 5'b01010);
    #399; s5 = 1'b0; #1; check("w5_s0_b", out5, 5'b10101);
    #399; s5 = 1'b1; #1; check("w5_s1_b", out5, 5'b01010);
    d5 = {5'b11001, 5'b11001}; s5 = 1'bx; #1; check("w5_cons", out5, 5'b11001);
    s5 = 1'b0;

    // Registered WIDTH=5: reset edge clears output
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; check("r_reset", outr, 5'b00000);

    // Release with s=1, leg1 all ones: unchanged before the edge, loaded after
    @(negedge clk); reset = 1'b0; sr = 1'b1; dr = {5'b11111, 5'b00000};
    #1; check("r_before_edge", outr, 5'b00000);
    @(posedge clk); #1; check("r_load_leg1", outr, 5'b11111);

    // Reset mid-stream clears on that edge even with data present
    @(negedge clk); reset = 1'b1;
    #1; check("r_hold_pre_rst", outr, 5'b11111);
    @(posedge clk); #1; check("r_mid_reset", outr, 5'b00000);

    // Deassert: next edge reloads the selection
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; check("r_reload", outr, 5'b11111);

    // Switch to leg0: one-cycle latency, holds between edges
    @(negedge clk); sr = 1'b0; dr = {5'b11111, 5'b10101};
    #1; check("r_hold_leg1", outr, 5'b11111);
    @(posedge clk); #1; check("r_load_leg0", outr, 5'b10101);
    @(negedge clk); check("r_hold_leg0", outr, 5'b10101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
